// File: rtl/z_csa_seq_ctrl.sv
`default_nettype none
// ==================================================================================
// z_csa_seq_ctrl: walks a K*M-bit addition through one shared M-bit adder stage.
// Revision: 1.0
// ==================================================================================
module z_csa_seq_ctrl #(
  parameter int K = 8,
  parameter int M = 4,
  localparam int N = K * M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic [M-1:0] stg_a,
  output logic [M-1:0] stg_b,
  output logic         stg_cin,
  input  logic [M-1:0] stg_sum,
  input  logic         stg_cout
);

  localparam int IDXW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;
  logic            accept;

  // A request is accepted only from IDLE or DONE; DONE acceptance gives back-to-back operation.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          sum_d[int'(idx_q) * M +: M] = stg_sum;
          carry_d = stg_cout;
          if (idx_q == C_LAST_IDX) begin
            c_out_d = stg_cout;
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign sum     = sum_q;
  assign c_out   = c_out_q;
  assign stg_a   = busy ? a_q[int'(idx_q) * M +: M] : '0;
  assign stg_b   = busy ? b_q[int'(idx_q) * M +: M] : '0;
  assign stg_cin = busy & carry_q;

endmodule
`default_nettype wire

// File: tb/tb_z_csa_seq_ctrl.sv
`default_nettype none
// ==================================================================================
// tb_z_csa_seq_ctrl: directed bench with arithmetic reference model for z_csa_seq_ctrl.
// Revision: 1.0
// ==================================================================================
module tb_z_csa_seq_ctrl;

  localparam int K = 8;
  localparam int M = 4;
  localparam int N = K * M;

  logic         clk, rst_n, start, abort, c_in;
  logic [N-1:0] a, b;
  logic         busy, done, c_out, stg_cin, stg_cout;
  logic [N-1:0] sum;
  logic [M-1:0] stg_a, stg_b, stg_sum;

  int n_tests = 0;
  int n_fail  = 0;

  z_csa_seq_ctrl #(.K(K), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out),
    .stg_a(stg_a), .stg_b(stg_b), .stg_cin(stg_cin),
    .stg_sum(stg_sum), .stg_cout(stg_cout)
  );

  // Shared adder stage the controller drives.
  assign {stg_cout, stg_sum} = {1'b0, stg_a} + {1'b0, stg_b} + {4'b0, stg_cin};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an operation is a run of K slices after acceptance; result is a+b+c_in.
  logic        m_run, m_done, m_cin;
  int          m_slice;
  logic [31:0] m_a, m_b;
  logic [32:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_done <= 0; m_slice <= 0; m_cin <= 0;
      m_a <= 0; m_b <= 0; m_res <= 0;
    end else begin
      m_done <= m_run && !abort && (m_slice == K - 1);
      if (m_run) begin
        if (abort || m_slice == K - 1) m_run <= 0;
        else m_slice <= m_slice + 1;
      end else if (start) begin
        m_run   <= 1;
        m_slice <= 0;
        m_a     <= a;
        m_b     <= b;
        m_cin   <= c_in;
        m_res   <= {1'b0, a} + {1'b0, b} + 33'(c_in);
      end
    end
  end

  logic [63:0] e_mask, e_low;
  logic [3:0]  e_a, e_b;
  logic        e_cin;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_run) begin
        e_mask = (64'd1 << (4 * m_slice)) - 64'd1;
        e_low  = ({32'b0, m_a} & e_mask) + ({32'b0, m_b} & e_mask) + 64'(m_cin);
        e_cin  = e_low[4 * m_slice];
        e_a    = 4'((m_a >> (4 * m_slice)) & 32'hF);
        e_b    = 4'((m_b >> (4 * m_slice)) & 32'hF);
      end else begin
        e_cin = 0; e_a = 0; e_b = 0;
      end
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("stg_a", stg_a, e_a);
      chk("stg_b", stg_b, e_b);
      chk("stg_cin", stg_cin, e_cin);
      if (m_done) begin
        chk("sum", sum, m_res[31:0]);
        chk("c_out", c_out, m_res[32]);
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 0;
      lat++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic ci);
    int lat;
    @(negedge clk);
    a = ai; b = bi; c_in = ci; start = 1;
    wait_done(lat);
  endtask

  int lat, bc, seen;
  int exp_nib [8] = '{8, 7, 6, 5, 4, 3, 2, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst_n = 1; start = 0; abort = 0; a = 0; b = 0; c_in = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_stg_a", stg_a, 0);
    chk("rst_stg_cin", stg_cin, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;

    // abort while idle does nothing
    @(negedge clk); abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_idle_busy", busy, 0);

    // full carry ripple, latency and busy length
    @(negedge clk);
    a = 32'h0000_0001; b = 32'hFFFF_FFFF; c_in = 0; start = 1;
    lat = 0; bc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 0;
      lat++;
      if (busy) bc++;
      if (done) break;
    end
    chk("t1_latency", lat, 9);
    chk("t1_busy_cycles", bc, 8);
    chk("t1_sum", sum, 32'h0000_0000);
    chk("t1_cout", c_out, 1);

    // slice drive sequence
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; c_in = 1; start = 1;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      start = 0;
      chk("t2_stg_a", stg_a, exp_nib[s]);
      chk("t2_stg_cin", stg_cin, (s == 0));
    end
    @(negedge clk);
    chk("t2_done", done, 1);
    chk("t2_sum", sum, 32'h2345_678A);
    chk("t2_cout", c_out, 0);

    // start during RUN is ignored
    @(negedge clk);
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; c_in = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1; start = 1;
    @(negedge clk);
    chk("t3_busy", busy, 1);
    start = 0;
    wait_done(lat);
    chk("t3_sum", sum, 32'h1010_1010);
    chk("t3_cout", c_out, 0);

    // back-to-back through DONE
    @(negedge clk);
    a = 32'h0000_0010; b = 32'h0000_0020; c_in = 0; start = 1;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0000_0000; c_in = 1;
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("t4_first_sum", sum, 32'h0000_0030);
    chk("t4_first_cout", c_out, 0);
    @(negedge clk);
    chk("t4_no_bubble", busy, 1);
    start = 0;
    wait_done(lat);
    chk("t4_second_sum", sum, 32'h0000_0000);
    chk("t4_second_cout", c_out, 1);

    // async reset on slice 4
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1111_1111; c_in = 0; start = 1;
    repeat (5) begin
      @(negedge clk);
      start = 0;
    end
    #1 rst_n = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_sum", sum, 0);
    chk("t5_cout", c_out, 0);
    chk("t5_stg_a", stg_a, 0);
    @(negedge clk);
    #1 rst_n = 1;
    run_op(32'hDEAD_BEEF, 32'h1111_1111, 0);
    chk("t5_sum_after", sum, 32'hEFBE_D000);
    chk("t5_cout_after", c_out, 0);

    // abort on slice 2, with a competing start
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h8765_4321; c_in = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    abort = 1; start = 1; a = 32'h1; b = 32'h1;
    @(negedge clk);
    abort = 0; start = 0;
    chk("t6_busy", busy, 0);
    chk("t6_stg_a", stg_a, 0);
    chk("t6_stg_b", stg_b, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("t6_no_done", seen, 0);
    run_op(32'd5, 32'd7, 0);
    chk("t6_sum", sum, 32'd12);
    chk("t6_cout", c_out, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z_csa_seq_ctrl.md
Name: z_csa_seq_ctrl

Overview:
Sequencing controller that time-multiplexes one external m-bit carry-select adder stage across an n-bit (k*m) addition. It latches the operands on a start handshake and walks the k slices LSB-first, one per clock. Each cycle it feeds the stage the current slice and the rippled carry, and writes the stage result back into a result register. It sits between a requester and a single shared z_m_sca_stage instance, trading k cycles of latency for one stage's area.

Parameters:
k, 8, number of slices (cycles per addition)
m, 4, slice width in bits; width of the shared stage
n, k*m, full operand width (derived; not overridden independently)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
abort  input  1  synchronous cancel of an operation in progress
a  input  n  operand A, sampled on accepted start
b  input  n  operand B, sampled on accepted start
c_in  input  1  carry-in, sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum/c_out valid
sum  output  n  registered result
c_out  output  1  registered carry-out of the full addition
stg_a  output  m  slice of A driven to shared stage
stg_b  output  m  slice of B driven to shared stage
stg_cin  output  1  carry into shared stage
stg_sum  input  m  stage sum (combinational from stg_a/stg_b/stg_cin)
stg_cout  input  1  stage carry-out

Behaviour:
- Reset (rst_n=0, async): state=IDLE; idx=0; carry reg=0; a_reg, b_reg, sum, c_out=0; busy=0, done=0. Outputs are forced immediately, without waiting for a clock edge. Reset mid-RUN discards the operation.
- State machine: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch a, b, c_in into a_reg, b_reg, carry; idx<=0; go to RUN. start=0 -> stay in IDLE.
  - RUN, each edge: sum[idx*m +: m] <= stg_sum; carry <= stg_cout; idx <= idx+1.
    - When idx==k-1: c_out <= stg_cout; idx <= 0; go to DONE.
    - abort=1 takes priority: go to IDLE, idx<=0, no slice write. sum and c_out keep partial/old contents.
  - DONE: done=1 for exactly this one cycle. Next edge: start=1 -> accept as in IDLE (back-to-back, no bubble); otherwise go to IDLE.
- Stage drive is combinational from registers:
  - stg_a = a_reg[idx*m +: m], stg_b = b_reg[idx*m +: m], stg_cin = carry while in RUN.
  - In IDLE and DONE the drive is all zeros (stg_cin=0).
- busy = (state==RUN); done = (state==DONE); both are decoded from registered state and are glitch-free.
- Latency: start sampled at edge E0 -> slices captured at E1..Ek -> done high during the cycle after Ek. Throughput is one addition per k+1 cycles with back-to-back starts.
- start during RUN is ignored (no queuing). a, b and c_in may change freely after acceptance.
- sum is written slice by slice. It is valid only when done=1 and holds until the next accepted start begins overwriting slices. c_out is updated only on the final slice.
- Arithmetic: {c_out, sum} == a + b + c_in modulo 2^(n+1). idx is $clog2(k) bits wide and never exceeds k-1.
- abort outside RUN has no effect. abort and start together in RUN: abort wins and start is ignored.

Test Plan:
- a=32'h0000_0001, b=32'hFFFF_FFFF, c_in=0, start pulse -> busy high 8 cycles; done 8 clocks after start edge; sum=32'h0000_0000, c_out=1; carry ripples through all slices.
- a=32'h1234_5678, b=32'h1111_1111, c_in=1 -> sum=32'h2345_678A, c_out=0. Check stg_a sequence 8,7,6,5,4,3,2,1 and stg_cin=1 on slice 0 only.
- Assert start again on cycle 3 of RUN with different operands -> ignored; result still matches the first operation; busy unchanged.
- Hold start high through DONE with a=32'hFFFF_FFFF, b=0, c_in=1 -> done pulses 1 cycle, RUN re-entered with no IDLE cycle; second result sum=0, c_out=1.
- Drop rst_n on slice 4 of RUN -> busy, done, sum, c_out go to 0 asynchronously, state IDLE. After release, a new start completes correctly.
- abort on slice 2 -> IDLE next edge, done never pulses, stg_* return to 0. A following start with a=5, b=7 gives sum=12.
